// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial "0101" scan controller.
//   - One-hot controller states (IDLE/SHIFT/REPORT) and detector states (S0..S3),
//     both as raw localparams and as typed enums built on those codes.
//   - eff_len(): maps a requested scan length onto the legal range 1..max_len.
package seq_scan_pkg;

  localparam logic [2:0] IDLE   = 3'b001;
  localparam logic [2:0] SHIFT  = 3'b010;
  localparam logic [2:0] REPORT = 3'b100;

  localparam logic [3:0] S0 = 4'h1;
  localparam logic [3:0] S1 = 4'h2;
  localparam logic [3:0] S2 = 4'h4;
  localparam logic [3:0] S3 = 4'h8;

  typedef enum logic [2:0] {
    StIdle   = IDLE,
    StShift  = SHIFT,
    StReport = REPORT
  } ctrl_state_e;

  typedef enum logic [3:0] {
    DetS0 = S0,
    DetS1 = S1,
    DetS2 = S2,
    DetS3 = S3
  } det_state_e;

  // Zero and oversize requests both mean "scan the whole word".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
    if (len == 0 || len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Handshake bundle between a word producer / result consumer and seq_scan_ctrl.
//   in_valid/in_ready/in_data/in_len : word offer (producer -> controller)
//   out_valid/out_ready              : result handshake (controller -> consumer)
//   match_cnt/first_pos/found        : scan result, stable while out_valid
//   busy                             : controller is scanning or reporting
// Modports: master = producer/consumer side, slave = controller side.
interface seq_scan_ctrl_if #(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned LEN_W  = 5,
  parameter int unsigned CNT_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LEN_W-1:0]  in_len;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  first_pos;
  logic              found;
  logic              busy;

  modport master (
    output in_valid, in_data, in_len, out_ready,
    input  in_ready, out_valid, match_cnt, first_pos, found, busy
  );

  modport slave (
    input  in_valid, in_data, in_len, out_ready,
    output in_ready, out_valid, match_cnt, first_pos, found, busy
  );

endinterface

// File: rtl/seq_det_0101.sv
// Serial Mealy detector for the bit sequence 0,1,0,1 (first bit first).
// Overlapping matches are detected: after a hit the machine keeps the trailing "01".
//   clk : clock          rst : synchronous active-high reset to S0
//   clr : return to S0 (wins over en)
//   en  : advance on sin this cycle
//   sin : serial input bit
//   hit : combinational, high when en && sin completes the pattern
module seq_det_0101
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sin,
  output logic hit
);

  det_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = DetS0;
    end else begin
      case (state_q)
        DetS0:   if (en) state_d = sin ? DetS0 : DetS1;
        DetS1:   if (en) state_d = sin ? DetS2 : DetS1;
        DetS2:   if (en) state_d = sin ? DetS0 : DetS3;
        DetS3:   if (en) state_d = sin ? DetS2 : DetS1;
        // Corrupted codes fall back to S0 regardless of en.
        default: state_d = DetS0;
      endcase
    end
  end

  assign hit = en && sin && (state_q == DetS3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DetS0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: accepts one word plus length, feeds it LSB-first into the
// "0101" detector one bit per clock, then reports the number of matches and
// the index of the bit that completed the first match.
//   clk : clock (posedge)     rst : synchronous active-high reset
//   bus : seq_scan_ctrl_if.slave
//         in_valid/in_ready/in_data/in_len  word input
//         out_valid/out_ready               result handshake
//         match_cnt/first_pos/found/busy    result and status
// Timing: accept cycle, then exactly L SHIFT cycles, then REPORT until out_ready.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned LEN_W  = 5,
  parameter int unsigned CNT_W  = 5
) (
  input  logic           clk,
  input  logic           rst,
  seq_scan_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  ctrl_state_e       state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  first_q, first_d;
  logic              found_q, found_d;
  logic [LEN_W-1:0]  len_eff;

  logic det_clr;
  logic det_en;
  logic det_hit;

  assign len_eff = LEN_W'(eff_len(32'(bus.in_len), DATA_W));

  seq_det_0101 u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .sin (sreg_q[0]),
    .hit (det_hit)
  );

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    len_d         = len_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    found_d       = found_q;
    det_clr       = 1'b0;
    det_en        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;

    case (state_q)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          sreg_d  = bus.in_data;
          len_d   = len_eff;
          idx_d   = '0;
          cnt_d   = '0;
          first_d = '0;
          found_d = 1'b0;
          det_clr = 1'b1;
          state_d = StShift;
        end
      end

      StShift: begin
        bus.busy = 1'b1;
        det_en   = 1'b1;
        sreg_d   = sreg_q >> 1;
        idx_d    = idx_q + 1'b1;
        if (det_hit) begin
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!found_q) begin
            first_d = CNT_W'(idx_q);
            found_d = 1'b1;
          end
        end
        if (idx_q == len_q - 1'b1) begin
          state_d = StReport;
        end
      end

      StReport: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus.match_cnt = cnt_q;
  assign bus.first_pos = first_q;
  assign bus.found     = found_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      found_q <= found_d;
    end
  end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Controller that sequences a serial "0101" Mealy sequence detector over a parallel word.
- Accepts one DATA_W-bit word plus a bit-length via valid/ready and shifts it LSB-first into the detector, one bit per clock.
- Counts detections, records the bit index of the first detection, and reports the result on a valid/ready output.
- Sits between a word producer and a result consumer; owns the detector exclusively.

Parameters:
- DATA_W, 21, word width and maximum scan length in bits.
- LEN_W, 5, width of in_len; must satisfy 2^LEN_W > DATA_W.
- CNT_W, 5, width of match_cnt and first_pos; equals $clog2(DATA_W+1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a word is offered.
- in_ready  output  1  the controller accepts a word this cycle.
- in_data  input  DATA_W  the word to scan; bit 0 is scanned first.
- in_len  input  LEN_W  number of bits to scan; 0 or values above DATA_W mean DATA_W.
- out_valid  output  1  result is valid.
- out_ready  input  1  the consumer takes the result.
- match_cnt  output  CNT_W  number of detections in the scanned bits (overlapping matches count).
- first_pos  output  CNT_W  0-based index of the bit that completed the first match; 0 if found=0.
- found  output  1  match_cnt is non-zero.
- busy  output  1  high in SHIFT or REPORT.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; detector S0; in_ready=1; out_valid=0; match_cnt=0; first_pos=0; found=0; busy=0.
- Reset mid-operation aborts the scan. No result is reported, and the accumulated count is discarded.
- Controller FSM, one-hot: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture in_data into the shift register and the effective length L (1..DATA_W).
  - Also on that handshake: clear the bit index, match_cnt, first_pos and found; clear the detector to S0; go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: present sreg[0] to the detector as sin with en=1, shift sreg right by 1, and increment the bit index.
  - On a detector hit at bit index i: match_cnt increments, saturating at 2^CNT_W-1. If found=0, set first_pos=i and found=1.
  - After processing index L-1, go to REPORT.
  - SHIFT lasts exactly L cycles.
- REPORT:
  - out_valid=1; all result outputs are held stable.
  - in_valid is ignored.
  - On out_ready, go to IDLE on the next edge, where out_valid=0 and in_ready=1.
- Latency: out_valid first asserts L+1 clocks after the accepting edge.
- Minimum word period is L+2 cycles; there is no back-to-back acceptance in REPORT.
- Detector state is not carried across words. Matches never span two words.
- Detector, Mealy, state one-hot S0=4'h1, S1=4'h2, S2=4'h4, S3=4'h8:
  - S0: sin=1 → S0; sin=0 → S1.
  - S1: sin=1 → S2; sin=0 → S1.
  - S2: sin=1 → S0; sin=0 → S3.
  - S3: sin=1 → S2; sin=0 → S1.
  - hit = en && sin && (state==S3), combinational.
  - The state advances only when en=1. clr has priority over en.
  - Unreachable state codes recover to S0.

Decomposition:
- Package seq_scan_pkg holds the controller state localparams (IDLE/SHIFT/REPORT one-hot) and the detector state localparams S0..S3.
- Sub-module seq_det_0101 has ports clk, rst, clr, en, sin, hit.
- The controller instantiates seq_det_0101 once.

Test Plan:
- in_data=21'h0000A, in_len=0 → 21 SHIFT cycles; match_cnt=1, first_pos=3, found=1; out_valid 22 clocks after accept.
- in_data=21'h0AAAAA, in_len=21 → match_cnt=9, first_pos=3, found=1 (overlapping matches at 3,5,…,19).
- in_data=21'h1FFFFF, in_len=21 → match_cnt=0, first_pos=0, found=0, out_valid still asserts.
- in_data=21'h1FFFFA:
  - in_len=4 → match_cnt=1, first_pos=3, out_valid 5 clocks after accept.
  - Rerun with in_len=3 → match_cnt=0 (length boundary).
- Hold out_ready=0 for 10 cycles in REPORT with in_valid=1 → in_ready=0, outputs stable, no capture. Then out_ready=1 → next cycle in_ready=1, out_valid=0.
- Isolation and reset:
  - word1 in_data=21'h2, in_len=2, then word2 in_data=21'h2, in_len=2 → both report match_cnt=0 (no cross-word state).
  - Assert rst during bit 2 of a 21'h0AAAAA scan → next cycle IDLE, all outputs at reset values, no out_valid.
